// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file write-back block.
package regfile_writeback_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } WbWrite;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LOAD,
    WB_SKID,
    WB_ALU
  } WbSrc;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_writeback_wb_rd_fifo.sv
// In-order FIFO of load destination registers; exposes every slot and its
// validity so the owner can build a pending-register mask.
module wb_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [W-1:0]          head,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][W-1:0] entry_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]        offset;
  logic                    do_push, do_pop;

  // Both flags come straight from the registered count, so a pop in the
  // same cycle never lets a push into a full FIFO.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_comb begin
    entry_valid = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offset} < count_q);
    end
  end

  assign entry_data = mem_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; entry_valid masks stale slots,
  // and leaving it out keeps the array a plain register bank.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: load responses, a one-entry ALU skid and
// direct ALU results share one registered write port. Optional macro
// WB_BYPASS_EN adds a combinational read bypass of the registered write.
module regfile_writeback
  import regfile_writeback_pkg::REG_ADDR_W, regfile_writeback_pkg::NUM_REGS;
#(
  parameter int XLEN     = 32,
  parameter int LD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_rf,
  input  logic [XLEN-1:0]       rs2_rf,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
`endif
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue_valid,
  output logic                  ld_issue_ready,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic                  ld_resp_valid,
  output logic                  ld_resp_ready,
  input  logic [XLEN-1:0]       ld_resp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   pending_mask
);

  import regfile_writeback_pkg::WbSrc;
  import regfile_writeback_pkg::WB_NONE;
  import regfile_writeback_pkg::WB_LOAD;
  import regfile_writeback_pkg::WB_SKID;
  import regfile_writeback_pkg::WB_ALU;
  import regfile_writeback_pkg::rd_onehot;

  logic                           fifo_full, fifo_empty;
  logic [REG_ADDR_W-1:0]          fifo_head;
  logic [LD_DEPTH-1:0]            fifo_entry_valid;
  logic [LD_DEPTH-1:0][REG_ADDR_W-1:0] fifo_entry_data;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic [XLEN-1:0]       skid_data_q, skid_data_d;

  logic                  resp_fire, alu_fire;
  WbSrc                  wb_src;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]       win_data;

  wb_rd_fifo #(
    .DEPTH (LD_DEPTH),
    .W     (REG_ADDR_W)
  ) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (ld_issue_valid),
    .push_data   (ld_issue_rd),
    .pop         (ld_resp_valid),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head),
    .entry_valid (fifo_entry_valid),
    .entry_data  (fifo_entry_data)
  );

  // All readies are pure functions of registered state.
  assign ld_issue_ready = !fifo_full;
  assign ld_resp_ready  = !fifo_empty;
  assign alu_ready      = !skid_valid_q;

  assign resp_fire = ld_resp_valid && ld_resp_ready;
  assign alu_fire  = alu_valid && alu_ready;

  always_comb begin
    wb_src = WB_NONE;
    if (resp_fire) begin
      wb_src = WB_LOAD;
    end else if (skid_valid_q) begin
      wb_src = WB_SKID;
    end else if (alu_fire) begin
      wb_src = WB_ALU;
    end
  end

  always_comb begin
    win_rd       = '0;
    win_data     = '0;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    unique case (wb_src)
      WB_LOAD: begin
        win_rd   = fifo_head;
        win_data = ld_resp_data;
        // An ALU result that loses to a load parks in the skid.
        if (alu_fire) begin
          skid_valid_d = 1'b1;
          skid_rd_d    = alu_rd;
          skid_data_d  = alu_data;
        end
      end
      WB_SKID: begin
        win_rd       = skid_rd_q;
        win_data     = skid_data_q;
        skid_valid_d = 1'b0;
      end
      WB_ALU: begin
        win_rd   = alu_rd;
        win_data = alu_data;
      end
      default: ;
    endcase
  end

  // x0 winners consume their handshake but leave the write port untouched.
  always_comb begin
    rf_we_d    = (wb_src != WB_NONE) && (win_rd != '0);
    rf_waddr_d = rf_we_d ? win_rd   : rf_waddr_q;
    rf_wdata_d = rf_we_d ? win_data : rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (fifo_entry_valid[i]) begin
        pending_mask = pending_mask | rd_onehot(fifo_entry_data[i]);
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_data = (rf_we_q && (rf_waddr_q == rs1_addr) && (rs1_addr != '0)) ? rf_wdata_q : rs1_rf;
  assign rs2_data = (rf_we_q && (rf_waddr_q == rs2_addr) && (rs2_addr != '0)) ? rf_wdata_q : rs2_rf;
`endif

  // Issue logic must never send an ALU write to a register awaiting a load.
  alu_no_pending_hazard: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_valid && alu_ready && (alu_rd != '0) && pending_mask[alu_rd]));

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer side of the 32x32 register file write port.
- Merges ALU results and in-order load responses into the single port, driving `rf_we`, `rf_waddr` and `rf_wdata` one cycle after acceptance.
- Tracks outstanding loads and exports a per-register pending mask for the issue-stage hazard logic.
- Sits between execute/memory and the register file.

Parameters:
- `XLEN`, 32, data width.
- `LD_DEPTH`, 4, max outstanding loads (power of two, ≥2).

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `alu_valid`  in  1  ALU result present
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `ld_issue_valid`  in  1  load issued to memory
- `ld_issue_ready`  out  1  tracking slot free
- `ld_issue_rd`  in  5  load destination
- `ld_resp_valid`  in  1  memory load data present
- `ld_resp_ready`  out  1  load data accepted
- `ld_resp_data`  in  XLEN  load data
- `rf_we`  out  1  register file write enable (registered)
- `rf_waddr`  out  5  write address (registered)
- `rf_wdata`  out  XLEN  write data (registered)
- `pending_mask`  out  32  bit i set while any outstanding load targets xi

Behaviour:
- **Reset** (`rst_n`=0 at posedge):
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - rd FIFO empty; skid empty.
  - Therefore `alu_ready`=1, `ld_issue_ready`=1, `ld_resp_ready`=0, `pending_mask`=0.
  - Reset mid-operation discards all outstanding loads and any skid entry; no write follows.
- **Handshake rules:**
  - Every handshake completes on a posedge with valid&ready.
  - Ready signals depend only on state, never on valid inputs.
- **Load tracking:**
  - In-order rd FIFO, `LD_DEPTH` entries.
  - `ld_issue_ready` = !full. Issue pushes `ld_issue_rd`.
  - `ld_resp_ready` = !empty. A response pops the head rd.
  - Push and pop in the same cycle are allowed, including when full if the pop makes room? No: `ld_issue_ready` uses the registered full flag only.
  - A response while the FIFO is empty is never consumed.
- **`pending_mask`:** combinational OR over valid FIFO entries of onehot(rd). A popped entry clears its bit in the cycle after the pop.
- **Write port arbitration** (priority high→low):
  1. Accepted load response.
  2. Skid entry.
  3. Accepted ALU result.
- **ALU skid buffer:** `alu_ready` = !skid_valid.
  - ALU accepted in the same cycle as a load response → ALU goes into the skid.
  - Otherwise ALU writes directly.
  - The skid drains in the first cycle with no load response.
  - While the skid is held, further load responses keep winning; the skid waits.
- **Latency:** the winning source is registered into `rf_*` at the accepting edge, so the write is visible in the register file one edge later.
- **x0:** a winner with rd=0 still consumes its slot/handshake, but `rf_we`=0 for that cycle.
- **No winner:** `rf_we`=0. `rf_waddr` and `rf_wdata` hold their previous values.
- **Hazard contract:** ALU writing a register whose `pending_mask` bit is set is a protocol violation. Flag it with an assertion; the block does not reorder.

Optional Feature:
- Macro: `WB_BYPASS_EN`.
- **Defined:** adds the following ports:
  - inputs `rs1_addr`[4:0], `rs2_addr`[4:0], `rs1_rf`[XLEN], `rs2_rf`[XLEN];
  - outputs `rs1_data`, `rs2_data`.
  - Each output returns `rf_wdata` when `rf_we` && `rf_waddr`==rsN_addr && rsN_addr!=0; otherwise it returns rsN_rf.
  - The bypass is purely combinational.
- **Undefined:** these ports are absent; consumers read the register file directly and see writes one cycle later.

Decomposition:
- Package `Bundle` gains:
  - `XLEN`, `REG_ADDR_W`=5, `NUM_REGS`=32;
  - typedef `WbWrite` {we, waddr, wdata};
  - typedef `WbSrc` enum {WB_NONE, WB_LOAD, WB_SKID, WB_ALU}.
- One sub-module: `wb_rd_fifo`, a parameterised in-order FIFO of 5-bit rd with full/empty and entry-valid/contents exposed for mask generation.

Test Plan:
- **Reset:** mid-traffic reset with 2 loads outstanding → next cycle `rf_we`=0, `pending_mask`=0, `ld_resp_ready`=0, `alu_ready`=1.
- **Single ALU write:** ALU rd=5 data=0xDEADBEEF for one cycle → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; the following cycle `rf_we`=0.
- **Loads and mask:** issue loads rd=3 then rd=7 → `pending_mask`=0x88. Respond 0x11 then 0x22 → writes x3=0x11 then x7=0x22; mask goes 0x80, then 0x0.
- **Collision:** load response (rd=3, 0xAA) and ALU (rd=9, 0x55) in the same cycle → cycle+1 writes x3=0xAA; `alu_ready`=0 at cycle+1; cycle+2 writes x9=0x55.
- **FIFO full / empty:** 4 issues with no responses → `ld_issue_ready`=0. Response with an empty FIFO → `ld_resp_ready`=0, no write.
- **x0 and bypass:**
  - ALU rd=0 data=0x1234 → `rf_we` stays 0 and `alu_ready` stays 1.
  - With `WB_BYPASS_EN`, write to x4 with `rs1_addr`=4 → `rs1_data`=`rf_wdata` in the `rf_we` cycle.
